prbs_checker: RTL and testbench

Receive-side companion to the design's 32-bit PRBS generator. Consumes a stream of 32-bit words over a valid/ready handshake, synchronises a local predictor to the incoming sequence, and once locked, compares every word against the prediction, counting word and bit errors. Sits at the output of the ChaCha20 decrypt path (or directly on a loopback) so a PRBS plaintext can be checked end to end in hardware.

---
 rtl/prbs_checker.sv | 192 +++++++++++++++++++
 tb/tb_prbs_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// prbs_checker: receive-side checker for the 32-bit PRBS stream.
// The checker locks a local predictor to the incoming words. Once it is locked, it compares
// each accepted word against the prediction and counts word errors and bit errors.
//
// Parameters
//   LOCK_CNT    consecutive matches after seeding needed to declare lock (>= 1)
//   UNLOCK_CNT  consecutive mismatches while locked that drop lock (>= 1)
//   CNT_W       width of the statistics counters
// Ports
//   i_aclk, i_aresetn   clock and asynchronous active-low reset
//   i_enable            1 = run, 0 = return to idle (counters hold)
//   i_clear             synchronous clear of the statistics counters
//   i_tvalid, i_tdata   input word stream; o_tready is 1 once out of reset
//   o_locked            predictor synchronised
//   o_err_pulse         one-cycle pulse per mismatching beat while locked
//   o_word_cnt          beats checked while locked
//   o_err_word_cnt      mismatching beats while locked
//   o_err_bit_cnt       total differing bits while locked (saturating)
module prbs_checker #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             i_aclk,
  input  logic             i_aresetn,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic             i_tvalid,
  input  logic [31:0]      i_tdata,
  output logic             o_tready,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [CNT_W-1:0] o_word_cnt,
  output logic [CNT_W-1:0] o_err_word_cnt,
  output logic [CNT_W-1:0] o_err_bit_cnt
);

  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW  = $clog2(UNLOCK_CNT + 1);
  // Wide enough to hold a full counter plus a 32-bit popcount without wrapping.
  localparam int unsigned SumW   = ((CNT_W > 6) ? CNT_W : 6) + 1;
  localparam logic [CNT_W-1:0]  CntMax  = '1;
  localparam logic [MatchW-1:0] LockM   = MatchW'(LOCK_CNT);
  localparam logic [MissW-1:0]  UnlockM = MissW'(UNLOCK_CNT);

  typedef enum logic [1:0] {StIdle, StSeed, StSearch, StLocked} state_e;

  state_e            state_q;
  logic [31:0]       pred_q;
  logic [MatchW-1:0] match_q;
  logic [MissW-1:0]  miss_q;
  logic              tready_q;
  logic              locked_q;
  logic              err_pulse_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [CNT_W-1:0]  err_word_cnt_q;
  logic [CNT_W-1:0]  err_bit_cnt_q;

  logic              accept;
  logic              hit;
  logic [31:0]       diff;
  logic [5:0]        popcnt;
  logic [MatchW-1:0] match_inc;
  logic [MissW-1:0]  miss_inc;
  logic [SumW-1:0]   bit_sum;
  logic [CNT_W-1:0]  bit_sat;

  function automatic logic [31:0] prbs_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[26] ^ s[15]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CNT_W'(1);
  endfunction

  assign accept    = i_tvalid & tready_q & i_enable;
  assign diff      = i_tdata ^ pred_q;
  assign hit       = (diff == 32'h0);
  assign match_inc = match_q + MatchW'(1);
  assign miss_inc  = miss_q + MissW'(1);

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < 32; i++) begin
      popcnt = popcnt + 6'(diff[i]);
    end
  end

  assign bit_sum = SumW'(err_bit_cnt_q) + SumW'(popcnt);
  assign bit_sat = (bit_sum > SumW'(CntMax)) ? CntMax : bit_sum[CNT_W-1:0];

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q        <= StIdle;
      pred_q         <= '0;
      match_q        <= '0;
      miss_q         <= '0;
      tready_q       <= 1'b0;
      locked_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      word_cnt_q     <= '0;
      err_word_cnt_q <= '0;
      err_bit_cnt_q  <= '0;
    end else begin
      tready_q    <= 1'b1;
      err_pulse_q <= 1'b0;

      if (!i_enable) begin
        state_q  <= StIdle;
        locked_q <= 1'b0;
        match_q  <= '0;
        miss_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StSeed;

          StSeed: begin
            if (accept) begin
              pred_q  <= prbs_next(i_tdata);
              match_q <= '0;
              state_q <= StSearch;
            end
          end

          StSearch: begin
            if (accept) begin
              if (hit) begin
                pred_q <= prbs_next(pred_q);
                if (match_inc == LockM) begin
                  state_q  <= StLocked;
                  locked_q <= 1'b1;
                  match_q  <= '0;
                  miss_q   <= '0;
                end else begin
                  match_q <= match_inc;
                end
              end else begin
                // Reseed from the offending word and start counting again.
                pred_q  <= prbs_next(i_tdata);
                match_q <= '0;
              end
            end
          end

          StLocked: begin
            if (accept) begin
              // The predictor free-runs so a single bad word does not cause cascaded errors.
              pred_q <= prbs_next(pred_q);
              if (hit) begin
                miss_q <= '0;
              end else begin
                err_pulse_q <= 1'b1;
                if (miss_inc == UnlockM) begin
                  state_q  <= StSearch;
                  locked_q <= 1'b0;
                  pred_q   <= prbs_next(i_tdata);
                  match_q  <= '0;
                  miss_q   <= '0;
                end else begin
                  miss_q <= miss_inc;
                end
              end
            end
          end

          default: state_q <= StIdle;
        endcase
      end

      // Clear takes priority over the contribution of a beat in the same cycle.
      if (i_clear) begin
        word_cnt_q     <= '0;
        err_word_cnt_q <= '0;
        err_bit_cnt_q  <= '0;
      end else if (accept && (state_q == StLocked)) begin
        word_cnt_q <= sat_inc(word_cnt_q);
        if (!hit) begin
          err_word_cnt_q <= sat_inc(err_word_cnt_q);
          err_bit_cnt_q  <= bit_sat;
        end
      end
    end
  end

  assign o_tready       = tready_q;
  assign o_locked       = locked_q;
  assign o_err_pulse    = err_pulse_q;
  assign o_word_cnt     = word_cnt_q;
  assign o_err_word_cnt = err_word_cnt_q;
  assign o_err_bit_cnt  = err_bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed testbench for prbs_checker: a vector table for lock, error and unlock behaviour,
// then hand-written sequences for gaps, clear, enable, reset and counter saturation.
module tb_prbs_checker;

  logic        clk;
  logic        aresetn;
  logic        enable;
  logic        clear;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tready;
  logic        locked;
  logic        err_pulse;
  logic [31:0] word_cnt;
  logic [31:0] err_word_cnt;
  logic [31:0] err_bit_cnt;

  logic        s_enable;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tready;
  logic        s_locked;
  logic        s_err_pulse;
  logic [3:0]  s_word_cnt;
  logic [3:0]  s_err_word_cnt;
  logic [3:0]  s_err_bit_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] g;   // generator state for the main DUT
  logic [31:0] sg;  // generator state for the saturation DUT

  prbs_checker u_dut (
    .i_aclk         (clk),
    .i_aresetn      (aresetn),
    .i_enable       (enable),
    .i_clear        (clear),
    .i_tvalid       (tvalid),
    .i_tdata        (tdata),
    .o_tready       (tready),
    .o_locked       (locked),
    .o_err_pulse    (err_pulse),
    .o_word_cnt     (word_cnt),
    .o_err_word_cnt (err_word_cnt),
    .o_err_bit_cnt  (err_bit_cnt)
  );

  prbs_checker #(
    .LOCK_CNT   (4),
    .UNLOCK_CNT (64),
    .CNT_W      (4)
  ) u_sat (
    .i_aclk         (clk),
    .i_aresetn      (aresetn),
    .i_enable       (s_enable),
    .i_clear        (1'b0),
    .i_tvalid       (s_tvalid),
    .i_tdata        (s_tdata),
    .o_tready       (s_tready),
    .o_locked       (s_locked),
    .o_err_pulse    (s_err_pulse),
    .o_word_cnt     (s_word_cnt),
    .o_err_word_cnt (s_err_word_cnt),
    .o_err_bit_cnt  (s_err_bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[26] ^ s[15]};
  endfunction

  typedef struct {
    logic        valid;
    logic [31:0] mask;
    logic        clr;
    logic        locked;
    logic        pulse;
    logic [31:0] words;
    logic [31:0] errw;
    logic [31:0] errb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [31:0] m, input logic c, input logic l,
                     input logic p, input int w, input int ew, input int eb);
    vec_t r;
    r.valid = v; r.mask = m; r.clr = c; r.locked = l; r.pulse = p;
    r.words = w; r.errw = ew; r.errb = eb;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [97:0] act, input logic [97:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample as {locked, pulse, word_cnt, err_word_cnt, err_bit_cnt}.
  function automatic logic [97:0] snap();
    return {locked, err_pulse, word_cnt, err_word_cnt, err_bit_cnt};
  endfunction

  // Called at a falling edge: drive one cycle of input, return at the next falling edge.
  task automatic step(input logic v, input logic [31:0] m, input logic c);
    tvalid = v;
    tdata  = g ^ m;
    clear  = c;
    @(negedge clk);
    if (v) g = nxt(g);
    tvalid = 1'b0;
    clear  = 1'b0;
  endtask

  task automatic s_step(input logic [31:0] m);
    s_tvalid = 1'b1;
    s_tdata  = sg ^ m;
    @(negedge clk);
    sg = nxt(sg);
    s_tvalid = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; enable = 1'b0; clear = 1'b0; tvalid = 1'b0; tdata = '0;
    s_enable = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
    g = 32'h0000ACE1;
    sg = 32'h0000ACE1;

    // Build the vector table: 20 clean beats, one corrupted beat, a gap, clear,
    // eight single-bit-corrupted beats (unlock), then a clean relock.
    for (int k = 1; k <= 20; k++) add(1, 0, 0, k >= 5, 0, (k > 5) ? k - 5 : 0, 0, 0);
    add(1, 32'h5, 0, 1, 1, 16, 1, 2);
    add(1, 0, 0, 1, 0, 17, 1, 2);
    add(0, 0, 0, 1, 0, 17, 1, 2);
    add(1, 0, 0, 1, 0, 18, 1, 2);
    add(0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) add(1, 32'h80000000, 0, i < 8, 1, i, i, i);
    for (int i = 1; i <= 5; i++) add(1, 0, 0, i == 5, 0, 8, 8, 8);
    add(1, 0, 0, 1, 0, 9, 8, 8);

    // Reset state.
    #2;
    chk("reset_tready", {97'h0, tready}, 98'h0);
    chk("reset_outputs", snap(), 98'h0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk("tready_after_reset", {97'h0, tready}, 98'h1);

    // IDLE -> SEED before streaming, so the first beat seeds.
    enable = 1'b1;
    step(0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].valid, vecs[i].mask, vecs[i].clr);
      chk($sformatf("vec%0d", i), snap(),
          {vecs[i].locked, vecs[i].pulse, vecs[i].words, vecs[i].errw, vecs[i].errb});
    end

    // Random valid gaps on a clean stream after a fresh reset.
    aresetn = 1'b0;
    #1;
    chk("reset_mid_run", {tready, snap()} , 99'h0);
    @(negedge clk);
    aresetn = 1'b1;
    g = 32'h0000ACE1;
    @(negedge clk);
    step(0, 0, 0);
    begin
      int beats = 0;
      for (int c = 0; c < 200 && beats < 20; c++) begin
        logic v;
        v = 1'($urandom_range(0, 1));
        step(v, 0, 0);
        if (v) beats++;
      end
      chk("gap_beats", {66'h0, beats[31:0]}, 98'd20);
    end
    chk("gap_stream", snap(), {1'b1, 1'b0, 32'd15, 32'd0, 32'd0});

    // Clear coincident with a corrupted beat: nothing counted, then a clean beat counts.
    step(1, 32'hFF, 1);
    chk("clear_with_err", {locked, word_cnt, err_word_cnt, err_bit_cnt},
        {1'b1, 32'd0, 32'd0, 32'd0});
    step(1, 0, 0);
    chk("after_clear", snap(), {1'b1, 1'b0, 32'd1, 32'd0, 32'd0});

    // Enable low mid-lock: unlock next cycle, counters hold, beats ignored.
    enable = 1'b0;
    step(1, 32'h1, 0);
    chk("enable_low", snap(), {1'b0, 1'b0, 32'd1, 32'd0, 32'd0});
    enable = 1'b1;
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("relock_pending", {97'h0, locked}, 98'h0);
    step(1, 0, 0);
    chk("relock_after_enable", snap(), {1'b1, 1'b0, 32'd1, 32'd0, 32'd0});

    // Asynchronous reset mid-lock, sampled before any clock edge.
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_reset", {tready, snap()}, 99'h0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);

    // Saturation with 4-bit counters.
    s_enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) s_step(0);
    chk("sat_locked", {94'h0, s_locked, s_word_cnt[2:0]}, {94'h0, 1'b1, 3'd0});
    s_step(32'hFFFFFFFF);
    chk("sat_first_err", {86'h0, s_word_cnt, s_err_word_cnt, s_err_bit_cnt},
        {86'h0, 4'd1, 4'd1, 4'd15});
    for (int i = 0; i < 20; i++) s_step(32'hFFFFFFFF);
    chk("sat_hold", {85'h0, s_locked, s_word_cnt, s_err_word_cnt, s_err_bit_cnt},
        {85'h0, 1'b1, 4'd15, 4'd15, 4'd15});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
